mskaes_128bits_round_sequencer: RTL
===================================

// Module: mskaes_128bits_round_sequencer
// PURPOSE
//  Iterative masked AES-128 encryption core built around one masked 128-bit round unit with cleaning.
//  Adds per-block sequencing: state/key share registers, round counter, RCON generation, final AddRoundKey.
//  Provides valid/ready handshakes on input and output, and a mandatory cleaning phase after every block.
//  Sits between the share-encoding front end and the unmasking/output stage of the full masked AES design.
// PARAMETERS
//  d            2   number of shares per bit
//  LATENCY      4   round-unit latency in cycles; must be >= 1
//  NR           10  number of AES rounds; must be in 1..10
//  CLEAN_CYCLES 4   cycles with cleaning active after each block; must be >= LATENCY
// PORTS
//  clk           in   1              clock, rising edge
//  rst_n         in   1              asynchronous reset, active low
//  in_valid      in   1              input block valid
//  in_ready      out  1              core can accept a block; high only in IDLE
//  sh_plaintext  in   128*d          shared plaintext
//  sh_key        in   128*d          shared cipher key
//  rnd_bus0w     in   20*rnd_bus0    fresh randomness, passed to the round unit
//  rnd_bus1w     in   20*rnd_bus1    fresh randomness, passed to the round unit
//  rnd_bus2w     in   20*rnd_bus2    fresh randomness, passed to the round unit
//  rnd_en        out  1              round unit is consuming randomness this cycle (ROUND/CLEAN)
//  out_valid     out  1              sh_ciphertext valid
//  out_ready     in   1              downstream accepts ciphertext
//  sh_ciphertext out  128*d          shared ciphertext, held stable while out_valid && !out_ready
//  busy          out  1              state != IDLE
// BEHAVIOUR
//  Reset (async, rst_n=0): FSM=IDLE; all share registers, counters and sh_ciphertext are 0.
//  Reset values: in_ready=1, out_valid=0, rnd_en=0, busy=0.
//  FSM states:
//   IDLE: in_valid&&in_ready -> load state_reg<=sh_plaintext, key_reg<=sh_key, rnd=1, cyc=0; go to ROUND.
//   ROUND: round unit is fed from state_reg/key_reg with cleaning_on=0; cyc counts 0..LATENCY-1.
//    - At cyc==LATENCY-1 with rnd<NR: state_reg<=state_out, key_reg<=key_out, rnd++, cyc=0.
//    - At cyc==LATENCY-1 with rnd==NR: state_reg<=state_SR_out (no MixColumns), key_reg<=key_out; go to FINAL.
//   FINAL (1 cycle): sh_ciphertext<=state_AK_out (state_reg^key_reg); go to OUT.
//   OUT: out_valid=1; on out_ready -> clear state_reg, key_reg and sh_ciphertext; go to CLEAN.
//   CLEAN: cleaning_on=1 for CLEAN_CYCLES cycles, then go to IDLE. Zero shares flush the pipelined SB/KS logic.
//  sh_RCON: public value shared as share0 = RCON[rnd], other shares 0.
//   Sequence: 01,02,04,08,10,20,40,80,1b,36. Driven constant for the whole round.
//  Latency: handshake in cycle 0 -> out_valid first high in cycle NR*LATENCY+2.
//   With defaults this is cycle 42.
//  Throughput: one block per NR*LATENCY+2+CLEAN_CYCLES+1 cycles minimum (out_ready tied high).
//  in_valid while busy is ignored; inputs are not sampled outside IDLE.
//  out_valid stays high with sh_ciphertext frozen until out_ready; no data loss under backpressure.
//  out_ready while out_valid=0 has no effect.
//  The round-unit inputs in IDLE and OUT are the (zeroed or held) registers.
//   No share of the next block is ever combined with a previous block before CLEAN completes.
//  rnd_en=1 in ROUND and CLEAN only; upstream supplies fresh randomness on every rnd_en cycle.
//  Mid-operation reset: immediate return to IDLE, all shares zeroed, no out_valid pulse.
//   The next block after release behaves exactly like the first block after power-up.
// TESTING
//  1 key 000102..0f, pt 00112233445566778899aabbccddeeff, random masks
//    -> unmasked ct 69c4e0d86a7b0430d8cdb78070b4c55a, out_valid at cycle 42.
//  2 key 2b7e151628aed2a6abf7158809cf4f3c, pt 3243f6a8885a308d313198a2e0370734
//    -> ct 3925841d02dc09fbdc118597196a0b32.
//  3 out_ready low for 20 cycles after out_valid -> ct stable and in_ready=0 throughout;
//    CLEAN starts the cycle after out_ready rises.
//  4 two back-to-back blocks with in_valid held high -> second accepted exactly CLEAN_CYCLES+1 cycles after first output handshake.
//    Both ciphertexts are correct.
//  5 rst_n pulsed low during round 5 -> outputs at reset values immediately; a new block then yields a correct ct.
//  6 NR=1, LATENCY=1 build: pt=0, key=0 -> ct equals SR(SB(0)) ^ KS1(0) (63636363... ^ 62636363...).
//    out_valid at cycle 3.

Source files
------------

// File: rtl/mskaes_128bits_round_sequencer.sv
//==============================================================================
// Module   : mskaes_128bits_round_sequencer
// Purpose  : Iterative masked AES-128 encryption core. One masked round unit
//            (ISW-masked S-boxes, share-wise linear layers, on-the-fly key
//            schedule) is reused for every round. Per-block sequencing covers
//            share registers, round counter, RCON, final AddRoundKey,
//            valid/ready handshakes and a mandatory cleaning phase.
// Revision : 1.0 - initial release
//==============================================================================
`default_nettype none

module mskaes_128bits_round_sequencer #(
    parameter int D            = 2,   // shares per bit, >= 2
    parameter int LATENCY      = 4,   // round-unit latency, >= 1
    parameter int NR           = 10,  // AES rounds, 1..10
    parameter int CLEAN_CYCLES = 4,   // cleaning cycles, >= LATENCY
    localparam int NPAIR       = D * (D - 1) / 2,
    localparam int RND_BUS0    = 8 * NPAIR,
    localparam int RND_BUS1    = 8 * NPAIR,
    localparam int RND_BUS2    = 16 * NPAIR
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   in_valid_i,
    output logic                   in_ready_o,
    input  logic [128*D-1:0]       sh_plaintext_i,
    input  logic [128*D-1:0]       sh_key_i,
    input  logic [20*RND_BUS0-1:0] rnd_bus0w_i,
    input  logic [20*RND_BUS1-1:0] rnd_bus1w_i,
    input  logic [20*RND_BUS2-1:0] rnd_bus2w_i,
    output logic                   rnd_en_o,
    output logic                   out_valid_o,
    input  logic                   out_ready_i,
    output logic [128*D-1:0]       sh_ciphertext_o,
    output logic                   busy_o
);

    localparam int SW = 128 * D;                    // width of all shares of a 128-bit value
    localparam int CW = $clog2(CLEAN_CYCLES + 1);   // covers LATENCY too (CLEAN_CYCLES >= LATENCY)

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_ROUND = 3'd1,
        S_FINAL = 3'd2,
        S_OUT   = 3'd3,
        S_CLEAN = 3'd4
    } state_e;

    //--------------------------------------------------------------------------
    // GF(2^8) helpers (AES polynomial x^8+x^4+x^3+x+1)
    //--------------------------------------------------------------------------
    function automatic logic [7:0] xtime(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] x;
        p = 8'h00;
        x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ x;
            x = xtime(x);
        end
        return p;
    endfunction

    // Squaring is linear in GF(2^8), so it is applied to every share on its own.
    function automatic logic [8*D-1:0] msk_sq(input logic [8*D-1:0] a);
        logic [8*D-1:0] y;
        for (int s = 0; s < D; s++) y[8*s +: 8] = gf_mul(a[8*s +: 8], a[8*s +: 8]);
        return y;
    endfunction

    // ISW multiplication: one fresh byte per share pair keeps cross products masked.
    function automatic logic [8*D-1:0] msk_mul(input logic [8*D-1:0] a,
                                               input logic [8*D-1:0] b,
                                               input logic [8*NPAIR-1:0] r);
        logic [8*D-1:0] y;
        logic [7:0]     rij;
        logic [7:0]     rji;
        int             k;
        for (int i = 0; i < D; i++) y[8*i +: 8] = gf_mul(a[8*i +: 8], b[8*i +: 8]);
        k = 0;
        for (int i = 0; i < D; i++) begin
            for (int j = i + 1; j < D; j++) begin
                rij = r[8*k +: 8];
                rji = (rij ^ gf_mul(a[8*i +: 8], b[8*j +: 8])) ^ gf_mul(a[8*j +: 8], b[8*i +: 8]);
                y[8*i +: 8] = y[8*i +: 8] ^ rij;
                y[8*j +: 8] = y[8*j +: 8] ^ rji;
                k = k + 1;
            end
        end
        return y;
    endfunction

    // Masked S-box: inversion as x^254 (4 masked products), then the affine map.
    // The 0x63 constant only enters share 0.
    function automatic logic [8*D-1:0] msk_sbox(input logic [8*D-1:0]   x,
                                                 input logic [RND_BUS0-1:0] r0,
                                                 input logic [RND_BUS1-1:0] r1,
                                                 input logic [RND_BUS2-1:0] r2);
        logic [8*D-1:0] x2, x3, x12, x15, x240, x252, x254, y;
        logic [7:0]     b;
        x2   = msk_sq(x);
        x3   = msk_mul(x2, x, r0);
        x12  = msk_sq(msk_sq(x3));
        x15  = msk_mul(x12, x3, r1);
        x240 = msk_sq(msk_sq(msk_sq(msk_sq(x15))));
        x252 = msk_mul(x240, x12, r2[0 +: 8*NPAIR]);
        x254 = msk_mul(x252, x2, r2[8*NPAIR +: 8*NPAIR]);
        for (int s = 0; s < D; s++) begin
            b = x254[8*s +: 8];
            y[8*s +: 8] = b ^ {b[6:0], b[7]} ^ {b[5:0], b[7:6]} ^ {b[4:0], b[7:5]} ^ {b[3:0], b[7:4]};
        end
        y[7:0] = y[7:0] ^ 8'h63;
        return y;
    endfunction

    // Byte b of a 128-bit share lives at bits [127-8b -: 8]; AES byte index is 4*col+row.
    function automatic logic [127:0] shift_rows(input logic [127:0] v);
        logic [127:0] o;
        for (int c = 0; c < 4; c++)
            for (int r = 0; r < 4; r++)
                o[120 - 8*(4*c + r) +: 8] = v[120 - 8*(4*((c + r) % 4) + r) +: 8];
        return o;
    endfunction

    function automatic logic [127:0] mix_columns(input logic [127:0] v);
        logic [127:0] o;
        logic [7:0]   a0, a1, a2, a3;
        for (int c = 0; c < 4; c++) begin
            a0 = v[127 - 32*c -: 8];
            a1 = v[119 - 32*c -: 8];
            a2 = v[111 - 32*c -: 8];
            a3 = v[103 - 32*c -: 8];
            o[127 - 32*c -: 8] = xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3;
            o[119 - 32*c -: 8] = a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3;
            o[111 - 32*c -: 8] = a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3;
            o[103 - 32*c -: 8] = xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3);
        end
        return o;
    endfunction

    function automatic logic [7:0] rcon(input logic [3:0] rnd);
        case (rnd)
            4'd1:    return 8'h01;
            4'd2:    return 8'h02;
            4'd3:    return 8'h04;
            4'd4:    return 8'h08;
            4'd5:    return 8'h10;
            4'd6:    return 8'h20;
            4'd7:    return 8'h40;
            4'd8:    return 8'h80;
            4'd9:    return 8'h1b;
            4'd10:   return 8'h36;
            default: return 8'h00;
        endcase
    endfunction

    //--------------------------------------------------------------------------
    // Registers
    //--------------------------------------------------------------------------
    state_e          state_q;
    logic [SW-1:0]   state_sh_q;
    logic [SW-1:0]   key_sh_q;
    logic [SW-1:0]   ct_q;
    logic [3:0]      rnd_q;
    logic [CW-1:0]   cyc_q;
    logic            in_ready_q;
    logic            out_valid_q;
    logic            rnd_en_q;
    logic            busy_q;

    //--------------------------------------------------------------------------
    // Round unit
    //--------------------------------------------------------------------------
    logic            w_clean;
    logic [SW-1:0]   w_ru_state;
    logic [SW-1:0]   w_ru_key;
    logic [SW-1:0]   w_ak;
    logic [7:0]      w_rcon;
    logic [8*D-1:0]  w_sbi [20];
    logic [8*D-1:0]  w_sbo [20];
    logic [SW-1:0]   w_st_next;
    logic [SW-1:0]   w_st_sr;
    logic [SW-1:0]   w_key_next;
    logic [127:0]    w_lin_sb;
    logic [127:0]    w_lin_sr;
    logic [31:0]     w_lin_t;
    logic [127:0]    w_lin_k;
    logic [31:0]     w_kw0, w_kw1, w_kw2, w_kw3;
    logic [3*SW-1:0] w_ru_out;
    logic [3*SW-1:0] w_ru_dly;

    // While cleaning, zero shares are forced into the unit to flush every stage.
    assign w_clean    = (state_q == S_CLEAN);
    assign w_ru_state = w_clean ? '0 : state_sh_q;
    assign w_ru_key   = w_clean ? '0 : key_sh_q;
    assign w_ak       = w_ru_state ^ w_ru_key;
    assign w_rcon     = w_clean ? 8'h00 : rcon(rnd_q);

    // Gather S-box inputs: 16 state bytes after AddRoundKey, then RotWord(w3) for the key schedule.
    always_comb begin
        for (int j = 0; j < 20; j++) w_sbi[j] = '0;
        for (int s = 0; s < D; s++) begin
            for (int j = 0; j < 16; j++)
                w_sbi[j][8*s +: 8] = w_ak[128*s + 120 - 8*j +: 8];
            for (int m = 0; m < 4; m++)
                w_sbi[16 + m][8*s +: 8] = w_ru_key[128*s + 120 - 8*(12 + (m + 1) % 4) +: 8];
        end
    end

    for (genvar j = 0; j < 20; j++) begin : g_sbox
        assign w_sbo[j] = msk_sbox(w_sbi[j],
                                   rnd_bus0w_i[j*RND_BUS0 +: RND_BUS0],
                                   rnd_bus1w_i[j*RND_BUS1 +: RND_BUS1],
                                   rnd_bus2w_i[j*RND_BUS2 +: RND_BUS2]);
    end

    // Share-wise linear layer: ShiftRows, MixColumns and key-word chaining; RCON joins share 0 only.
    always_comb begin
        w_st_next  = '0;
        w_st_sr    = '0;
        w_key_next = '0;
        w_lin_sb   = '0;
        w_lin_sr   = '0;
        w_lin_t    = '0;
        w_lin_k    = '0;
        w_kw0      = '0;
        w_kw1      = '0;
        w_kw2      = '0;
        w_kw3      = '0;
        for (int s = 0; s < D; s++) begin
            for (int j = 0; j < 16; j++)
                w_lin_sb[120 - 8*j +: 8] = w_sbo[j][8*s +: 8];
            w_lin_sr                = shift_rows(w_lin_sb);
            w_st_sr[128*s +: 128]   = w_lin_sr;
            w_st_next[128*s +: 128] = mix_columns(w_lin_sr);
            w_lin_t = {w_sbo[16][8*s +: 8], w_sbo[17][8*s +: 8],
                       w_sbo[18][8*s +: 8], w_sbo[19][8*s +: 8]};
            if (s == 0) w_lin_t[31:24] = w_lin_t[31:24] ^ w_rcon;
            w_lin_k = w_ru_key[128*s +: 128];
            w_kw0   = w_lin_k[127:96] ^ w_lin_t;
            w_kw1   = w_lin_k[95:64]  ^ w_kw0;
            w_kw2   = w_lin_k[63:32]  ^ w_kw1;
            w_kw3   = w_lin_k[31:0]   ^ w_kw2;
            w_key_next[128*s +: 128] = {w_kw0, w_kw1, w_kw2, w_kw3};
        end
    end

    assign w_ru_out = {w_st_next, w_st_sr, w_key_next};

    // LATENCY-1 register stages; a result is taken when cyc reaches LATENCY-1.
    if (LATENCY > 1) begin : g_pipe
        logic [3*SW-1:0] pipe_q [LATENCY-1];

        // Round-unit pipeline, flushed by the zero inputs of the cleaning phase.
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                for (int i = 0; i < LATENCY - 1; i++) pipe_q[i] <= '0;
            end else begin
                pipe_q[0] <= w_ru_out;
                for (int i = 1; i < LATENCY - 1; i++) pipe_q[i] <= pipe_q[i-1];
            end
        end

        assign w_ru_dly = pipe_q[LATENCY-2];
    end else begin : g_nopipe
        assign w_ru_dly = w_ru_out;
    end

    //--------------------------------------------------------------------------
    // Block sequencer
    //--------------------------------------------------------------------------
    // FSM with share registers, counters and registered handshake outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            state_sh_q  <= '0;
            key_sh_q    <= '0;
            ct_q        <= '0;
            rnd_q       <= '0;
            cyc_q       <= '0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            rnd_en_q    <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (in_valid_i && in_ready_q) begin
                        state_sh_q <= sh_plaintext_i;
                        key_sh_q   <= sh_key_i;
                        rnd_q      <= 4'd1;
                        cyc_q      <= '0;
                        in_ready_q <= 1'b0;
                        rnd_en_q   <= 1'b1;
                        busy_q     <= 1'b1;
                        state_q    <= S_ROUND;
                    end
                end
                S_ROUND: begin
                    if (cyc_q == CW'(LATENCY - 1)) begin
                        cyc_q    <= '0;
                        key_sh_q <= w_ru_dly[0 +: SW];
                        if (rnd_q == 4'(NR)) begin
                            // Last round skips MixColumns.
                            state_sh_q <= w_ru_dly[SW +: SW];
                            rnd_en_q   <= 1'b0;
                            state_q    <= S_FINAL;
                        end else begin
                            state_sh_q <= w_ru_dly[2*SW +: SW];
                            rnd_q      <= rnd_q + 4'd1;
                        end
                    end else begin
                        cyc_q <= cyc_q + 1'b1;
                    end
                end
                S_FINAL: begin
                    ct_q        <= state_sh_q ^ key_sh_q;
                    out_valid_q <= 1'b1;
                    state_q     <= S_OUT;
                end
                S_OUT: begin
                    if (out_ready_i) begin
                        state_sh_q  <= '0;
                        key_sh_q    <= '0;
                        ct_q        <= '0;
                        rnd_q       <= '0;
                        cyc_q       <= '0;
                        out_valid_q <= 1'b0;
                        rnd_en_q    <= 1'b1;
                        state_q     <= S_CLEAN;
                    end
                end
                S_CLEAN: begin
                    if (cyc_q == CW'(CLEAN_CYCLES - 1)) begin
                        cyc_q      <= '0;
                        rnd_en_q   <= 1'b0;
                        busy_q     <= 1'b0;
                        in_ready_q <= 1'b1;
                        state_q    <= S_IDLE;
                    end else begin
                        cyc_q <= cyc_q + 1'b1;
                    end
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign in_ready_o      = in_ready_q;
    assign out_valid_o     = out_valid_q;
    assign rnd_en_o        = rnd_en_q;
    assign busy_o          = busy_q;
    assign sh_ciphertext_o = ct_q;

endmodule

`default_nettype wire
